// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter that shares one single-ported synchronous memory between
// the MIPS core port and a boot/debug loader port, one transaction at a time.
module mips_mem_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_core_req,
  input  logic         i_core_we,
  input  logic [N-1:0] i_core_addr,
  input  logic [N-1:0] i_core_wdata,
  output logic         o_core_gnt,
  output logic         o_core_rvalid,
  input  logic         i_ldr_req,
  input  logic         i_ldr_we,
  input  logic [N-1:0] i_ldr_addr,
  input  logic [N-1:0] i_ldr_wdata,
  output logic         o_ldr_gnt,
  output logic         o_ldr_rvalid,
  output logic [N-1:0] o_rdata,
  output logic [N-1:0] o_mem_addr,
  output logic [N-1:0] o_mem_wdata,
  output logic         o_mem_we,
  output logic         o_mem_re,
  input  logic [N-1:0] i_mem_rdata,
  output logic         o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]   r_state;
  logic         r_owner;
  logic         r_last_owner;
  logic         r_we;
  logic [3:0]   r_cnt;

  logic         w_arb_req;
  logic         w_win;
  logic         w_win_we;
  logic [N-1:0] w_win_addr;
  logic [N-1:0] w_win_wdata;
  logic [1:0]   w_state_nxt;

  // On a tie the requester that did not own the last transaction wins
  always_comb begin
    w_arb_req = i_core_req | i_ldr_req;
    w_win     = OWN_CORE;
    if (i_core_req && i_ldr_req) begin
      w_win = ~r_last_owner;
    end else if (i_ldr_req) begin
      w_win = OWN_LDR;
    end else begin
      w_win = OWN_CORE;
    end
    if (w_win == OWN_LDR) begin
      w_win_we    = i_ldr_we;
      w_win_addr  = i_ldr_addr;
      w_win_wdata = i_ldr_wdata;
    end else begin
      w_win_we    = i_core_we;
      w_win_addr  = i_core_addr;
      w_win_wdata = i_core_wdata;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE, S_RESP: w_state_nxt = w_arb_req ? S_ISSUE : S_IDLE;
      S_ISSUE:        w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT:         w_state_nxt = (r_cnt == 4'd0) ? S_RESP : S_WAIT;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and pulses default low; the issue-cycle memory outputs are loaded
  // at the arbitration edge so they are valid throughout ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_CORE;
      r_last_owner  <= OWN_LDR;
      r_we          <= 1'b0;
      r_cnt         <= 4'd0;
      o_core_gnt    <= 1'b0;
      o_ldr_gnt     <= 1'b0;
      o_core_rvalid <= 1'b0;
      o_ldr_rvalid  <= 1'b0;
      o_rdata       <= '0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_we      <= 1'b0;
      o_mem_re      <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      o_busy        <= (w_state_nxt != S_IDLE);
      o_core_gnt    <= 1'b0;
      o_ldr_gnt     <= 1'b0;
      o_core_rvalid <= 1'b0;
      o_ldr_rvalid  <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_we      <= 1'b0;
      o_mem_re      <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_arb_req) begin
            r_we         <= w_win_we;
            r_owner      <= w_win;
            r_last_owner <= w_win;
            o_core_gnt   <= (w_win == OWN_CORE);
            o_ldr_gnt    <= (w_win == OWN_LDR);
            o_mem_addr   <= w_win_addr;
            o_mem_wdata  <= w_win_wdata;
            o_mem_we     <= w_win_we;
            o_mem_re     <= ~w_win_we;
          end
        end
        S_ISSUE: begin
          if (!r_we) begin
            r_cnt <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            o_rdata       <= i_mem_rdata;
            o_core_rvalid <= (r_owner == OWN_CORE);
            o_ldr_rvalid  <= (r_owner == OWN_LDR);
          end
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one LAT=1 and one LAT=3 instance, each
// with a latency-accurate memory model and a read-response scoreboard.
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic        own;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t a_exp_q[$];
  exp_t b_exp_q[$];

  // DUT A (LAT=1) signals
  logic        a_rst, a_core_req, a_core_we, a_ldr_req, a_ldr_we;
  logic [31:0] a_core_addr, a_core_wdata, a_ldr_addr, a_ldr_wdata, a_mem_rdata;
  logic        a_core_gnt, a_core_rvalid, a_ldr_gnt, a_ldr_rvalid;
  logic        a_mem_we, a_mem_re, a_busy;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
  logic        a_p_vld;
  logic [31:0] a_p_addr;

  // DUT B (LAT=3) signals
  logic        b_rst, b_core_req, b_core_we, b_ldr_req, b_ldr_we;
  logic [31:0] b_core_addr, b_core_wdata, b_ldr_addr, b_ldr_wdata, b_mem_rdata;
  logic        b_core_gnt, b_core_rvalid, b_ldr_gnt, b_ldr_rvalid;
  logic        b_mem_we, b_mem_re, b_busy;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
  logic [2:0]  b_p_vld;
  logic [31:0] b_p_addr [3];

  mips_mem_arbiter #(.N(32), .LAT(1)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .i_core_req(a_core_req), .i_core_we(a_core_we), .i_core_addr(a_core_addr),
    .i_core_wdata(a_core_wdata), .o_core_gnt(a_core_gnt), .o_core_rvalid(a_core_rvalid),
    .i_ldr_req(a_ldr_req), .i_ldr_we(a_ldr_we), .i_ldr_addr(a_ldr_addr),
    .i_ldr_wdata(a_ldr_wdata), .o_ldr_gnt(a_ldr_gnt), .o_ldr_rvalid(a_ldr_rvalid),
    .o_rdata(a_rdata), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .o_mem_we(a_mem_we), .o_mem_re(a_mem_re), .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
  );

  mips_mem_arbiter #(.N(32), .LAT(3)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_core_req(b_core_req), .i_core_we(b_core_we), .i_core_addr(b_core_addr),
    .i_core_wdata(b_core_wdata), .o_core_gnt(b_core_gnt), .o_core_rvalid(b_core_rvalid),
    .i_ldr_req(b_ldr_req), .i_ldr_we(b_ldr_we), .i_ldr_addr(b_ldr_addr),
    .i_ldr_wdata(b_ldr_wdata), .o_ldr_gnt(b_ldr_gnt), .o_ldr_rvalid(b_ldr_rvalid),
    .o_rdata(b_rdata), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_we(b_mem_we), .o_mem_re(b_mem_re), .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    if (addr == 32'h0040_0000) return 32'h8C08_0004;
    else if (addr == 32'h0000_0040) return 32'h1122_3344;
    else return addr ^ 32'h5A5A_5A5A;
  endfunction

  // Memory models: data is only valid exactly LAT cycles after the read strobe
  always @(posedge clk) begin
    a_p_vld    <= a_mem_re;
    a_p_addr   <= a_mem_addr;
    b_p_vld    <= {b_p_vld[1:0], b_mem_re};
    b_p_addr[0] <= b_mem_addr;
    b_p_addr[1] <= b_p_addr[0];
    b_p_addr[2] <= b_p_addr[1];
  end

  assign a_mem_rdata = a_p_vld    ? mem_val(a_p_addr)    : 32'hBAD0_BAD0;
  assign b_mem_rdata = b_p_vld[2] ? mem_val(b_p_addr[2]) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and exclusivity monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!a_rst) begin
      check("a_gnt_excl", 32'(a_core_gnt & a_ldr_gnt), 32'd0);
      check("a_rv_excl", 32'(a_core_rvalid & a_ldr_rvalid), 32'd0);
      check("a_strobe_excl", 32'(a_mem_we & a_mem_re), 32'd0);
      if (a_core_rvalid || a_ldr_rvalid) begin
        if (a_exp_q.size() == 0) check("a_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = a_exp_q.pop_front();
          check("a_rv_owner", 32'(a_ldr_rvalid), 32'(e.own));
          check("a_rdata_sb", a_rdata, e.data);
        end
      end
    end
    if (!b_rst) begin
      check("b_gnt_excl", 32'(b_core_gnt & b_ldr_gnt), 32'd0);
      if (b_core_rvalid || b_ldr_rvalid) begin
        if (b_exp_q.size() == 0) check("b_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = b_exp_q.pop_front();
          check("b_rv_owner", 32'(b_ldr_rvalid), 32'(e.own));
          check("b_rdata_sb", b_rdata, e.data);
        end
      end
    end
  end

  initial begin
    int core_cnt;
    logic [31:0] exp_addr;
    a_rst = 1'b1; b_rst = 1'b1;
    a_core_req = 1'b0; a_core_we = 1'b0; a_core_addr = 32'd0; a_core_wdata = 32'd0;
    a_ldr_req = 1'b0; a_ldr_we = 1'b0; a_ldr_addr = 32'd0; a_ldr_wdata = 32'd0;
    b_core_req = 1'b0; b_core_we = 1'b0; b_core_addr = 32'd0; b_core_wdata = 32'd0;
    b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = 32'd0; b_ldr_wdata = 32'd0;
    step(); step();
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_gnt", 32'({a_core_gnt, a_ldr_gnt, a_core_rvalid, a_ldr_rvalid}), 32'd0);
    check("rst_strobes", 32'({a_mem_we, a_mem_re}), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // Test 1: core read, LAT=1
    a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h0040_0000;
    a_exp_q.push_back('{own: 1'b0, data: 32'h8C08_0004});
    step();
    check("t1_c1_gnt", 32'({a_core_gnt, a_ldr_gnt}), 32'b10);
    check("t1_c1_re", 32'({a_mem_re, a_mem_we}), 32'b10);
    check("t1_c1_addr", a_mem_addr, 32'h0040_0000);
    check("t1_c1_busy", 32'(a_busy), 32'd1);
    a_core_req = 1'b0;
    step();
    check("t1_c2_busy", 32'(a_busy), 32'd1);
    check("t1_c2_quiet", 32'({a_core_gnt, a_mem_re, a_core_rvalid}), 32'd0);
    step();
    check("t1_c3_rvalid", 32'(a_core_rvalid), 32'd1);
    check("t1_c3_rdata", a_rdata, 32'h8C08_0004);
    check("t1_c3_busy", 32'(a_busy), 32'd1);
    step();
    check("t1_c4_busy", 32'(a_busy), 32'd0);
    check("t1_c4_rdata_hold", a_rdata, 32'h8C08_0004);

    // Test 2: core write
    a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h1001_0000; a_core_wdata = 32'hDEAD_BEEF;
    step();
    check("t2_c1_gnt", 32'(a_core_gnt), 32'd1);
    check("t2_c1_we", 32'({a_mem_we, a_mem_re}), 32'b10);
    check("t2_c1_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    check("t2_c1_addr", a_mem_addr, 32'h1001_0000);
    a_core_req = 1'b0;
    step();
    check("t2_c2_busy", 32'(a_busy), 32'd0);
    check("t2_c2_idle_bus", a_mem_wdata | a_mem_addr, 32'd0);
    step(); step();
    check("t2_no_rvalid", 32'(a_core_rvalid), 32'd0);

    // Test 3: tie after reset
    a_rst = 1'b1; step(); a_rst = 1'b0;
    a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h0000_1000;
    a_ldr_req = 1'b1; a_ldr_we = 1'b0; a_ldr_addr = 32'h0000_2000;
    a_exp_q.push_back('{own: 1'b0, data: mem_val(32'h0000_1000)});
    a_exp_q.push_back('{own: 1'b1, data: mem_val(32'h0000_2000)});
    step();
    check("t3_c1_core_first", 32'({a_core_gnt, a_ldr_gnt}), 32'b10);
    check("t3_c1_addr", a_mem_addr, 32'h0000_1000);
    a_core_req = 1'b0;
    step(); step();
    check("t3_c3_core_rvalid", 32'(a_core_rvalid), 32'd1);
    step();
    check("t3_c4_ldr_gnt", 32'({a_core_gnt, a_ldr_gnt}), 32'b01);
    check("t3_c4_addr", a_mem_addr, 32'h0000_2000);
    a_ldr_req = 1'b0;
    step(); step();
    check("t3_c6_ldr_rvalid", 32'(a_ldr_rvalid), 32'd1);
    a_core_req = 1'b1; a_core_addr = 32'h0000_3000;
    a_ldr_req = 1'b1; a_ldr_addr = 32'h0000_4000;
    a_exp_q.push_back('{own: 1'b0, data: mem_val(32'h0000_3000)});
    a_exp_q.push_back('{own: 1'b1, data: mem_val(32'h0000_4000)});
    step();
    check("t3_repeat_tie_core", 32'({a_core_gnt, a_ldr_gnt}), 32'b10);
    a_core_req = 1'b0;
    step(); step(); step();
    check("t3_repeat_ldr_gnt", 32'(a_ldr_gnt), 32'd1);
    a_ldr_req = 1'b0;
    step(); step(); step();
    check("t3_queue_drained", 32'(a_exp_q.size()), 32'd0);

    // Test 4: loader read, LAT=3
    b_ldr_req = 1'b1; b_ldr_we = 1'b0; b_ldr_addr = 32'h0000_0040;
    b_exp_q.push_back('{own: 1'b1, data: 32'h1122_3344});
    step();
    check("t4_c1_gnt", 32'({b_core_gnt, b_ldr_gnt}), 32'b01);
    check("t4_c1_re", 32'(b_mem_re), 32'd1);
    check("t4_c1_addr", b_mem_addr, 32'h0000_0040);
    b_ldr_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("t4_wait_no_rvalid", 32'({b_ldr_rvalid, b_core_rvalid}), 32'd0);
      check("t4_wait_busy", 32'(b_busy), 32'd1);
    end
    step();
    check("t4_c5_rvalid", 32'({b_core_rvalid, b_ldr_rvalid}), 32'b01);
    check("t4_c5_rdata", b_rdata, 32'h1122_3344);
    step();
    check("t4_c6_busy", 32'(b_busy), 32'd0);

    // Test 5: reset during WAIT discards the read
    a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h0040_0010;
    a_exp_q.push_back('{own: 1'b0, data: mem_val(32'h0040_0010)});
    step();
    check("t5_c1_gnt", 32'(a_core_gnt), 32'd1);
    a_core_req = 1'b0;
    step();
    a_rst = 1'b1;
    a_exp_q.delete();
    step();
    a_rst = 1'b0;
    check("t5_rst_outs", 32'({a_core_gnt, a_ldr_gnt, a_core_rvalid, a_ldr_rvalid, a_mem_we, a_mem_re, a_busy}), 32'd0);
    check("t5_rst_rdata", a_rdata, 32'd0);
    check("t5_rst_addr", a_mem_addr, 32'd0);
    step(); step();
    check("t5_no_rvalid", 32'({a_core_rvalid, a_ldr_rvalid}), 32'd0);
    check("t5_rdata_zero", a_rdata, 32'd0);
    a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h0000_0500;
    a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 32'h0000_0600;
    step();
    check("t5_tie_core", 32'({a_core_gnt, a_ldr_gnt}), 32'b10);
    a_core_req = 1'b0;
    step(); step();
    check("t5_then_ldr", 32'({a_core_gnt, a_ldr_gnt}), 32'b01);
    a_ldr_req = 1'b0;
    step();

    // Test 6: loader holds req while core issues 6 back-to-back writes
    core_cnt = 0;
    a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h0000_8000; a_core_wdata = 32'hC0DE_0000;
    a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 32'h0000_0100; a_ldr_wdata = 32'h1D1D_1D1D;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_addr = (i % 2 == 0) ? a_core_addr : 32'h0000_0100;
      check("t6_gnt_pattern", 32'({a_core_gnt, a_ldr_gnt}), (i % 2 == 0) ? 32'b10 : 32'b01);
      check("t6_mem_addr", a_mem_addr, exp_addr);
      if (a_core_gnt) begin
        core_cnt++;
        a_core_addr  = 32'h0000_8000 + 32'(core_cnt * 4);
        a_core_wdata = 32'hC0DE_0000 + 32'(core_cnt);
        if (core_cnt == 6) a_core_req = 1'b0;
      end
      if (i == 11) a_ldr_req = 1'b0;
      step();
      check("t6_gap", 32'({a_core_gnt, a_ldr_gnt}), 32'd0);
    end
    check("t6_core_grants", 32'(core_cnt), 32'd6);
    step(); step();
    check("end_a_queue", 32'(a_exp_q.size()), 32'd0);
    check("end_b_queue", 32'(b_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
